// File: rtl/li_rmw_ctrl_if.sv
// Request handshake plus register-file port bundle for the load-immediate sequencer.
// The master side is the requester/register file; the slave side is the controller.
interface li_rmw_ctrl_if #(
    parameter int DATA_W     = 16,
    parameter int IMM_W      = 8,
    parameter int REG_ADDR_W = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            req_opcode;
    logic [REG_ADDR_W-1:0] req_rd;
    logic [IMM_W-1:0]      req_imm;

    logic                  rf_rd_en;
    logic [REG_ADDR_W-1:0] rf_rd_addr;
    logic [DATA_W-1:0]     rf_rd_data;
    logic                  rf_wr_en;
    logic [REG_ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0]     rf_wr_data;

    modport master (
        output req_valid, req_opcode, req_rd, req_imm, rf_rd_data,
        input  req_ready, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data
    );

    modport slave (
        input  req_valid, req_opcode, req_rd, req_imm, rf_rd_data,
        output req_ready, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data
    );
endinterface

// File: rtl/li_rmw_ctrl.sv
// LHB/LLB read-modify-write sequencer: reads rd, merges the immediate byte,
// writes back; same-register back-to-back ops forward the written value.
module li_rmw_ctrl #(
    parameter int DATA_W     = 16,
    parameter int IMM_W      = 8,
    parameter int REG_ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    li_rmw_ctrl_if.slave bus,
    output logic        busy,
    output logic        done,
    output logic [15:0] li_count
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                state_q, state_d;
    logic                  rdy_q;
    logic                  fwd_q, fwd_d;
    logic [15:0]           count_q;
    logic                  llb_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [IMM_W-1:0]      imm_q;
    logic [DATA_W-1:0]     base_q;
    logic                  accept, latch;
    logic [DATA_W-1:0]     base, merged;
    logic                  unused_opc;

    function automatic logic [DATA_W-1:0] merge_imm(input logic llb,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic [IMM_W-1:0] imm);
        return llb ? {b[DATA_W-1:IMM_W], imm} : {imm, b[IMM_W-1:0]};
    endfunction

    assign unused_opc    = ^bus.req_opcode[3:1];
    // rdy_q keeps ready low while in reset and until the first edge after release
    assign bus.req_ready = rdy_q && (state_q != READ);
    assign accept        = bus.req_valid && bus.req_ready;
    assign base          = fwd_q ? base_q : bus.rf_rd_data;
    assign merged        = merge_imm(llb_q, base, imm_q);
    assign li_count      = count_q;

    always_comb begin
        state_d        = state_q;
        fwd_d          = 1'b0;
        latch          = 1'b0;
        bus.rf_rd_en   = 1'b0;
        bus.rf_rd_addr = '0;
        bus.rf_wr_en   = 1'b0;
        bus.rf_wr_addr = '0;
        bus.rf_wr_data = '0;
        done           = 1'b0;
        busy           = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = READ;
                    latch   = 1'b1;
                end
            end
            READ: begin
                bus.rf_rd_en   = 1'b1;
                bus.rf_rd_addr = rd_q;
                state_d        = WRITE;
            end
            WRITE: begin
                done = 1'b1;
                if (rd_q != '0) begin
                    bus.rf_wr_en   = 1'b1;
                    bus.rf_wr_addr = rd_q;
                    bus.rf_wr_data = merged;
                end
                if (accept) begin
                    latch = 1'b1;
                    // R0 reads as zero, so it never takes the forwarded value
                    if (bus.req_rd == rd_q && rd_q != '0) begin
                        state_d = WRITE;
                        fwd_d   = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            fwd_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            fwd_q   <= fwd_d;
            if (state_q == WRITE) count_q <= count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            llb_q <= bus.req_opcode[0];
            rd_q  <= bus.req_rd;
            imm_q <= bus.req_imm;
        end
        if (fwd_d) base_q <= merged;
    end
endmodule

// File: tb/tb_li_rmw_ctrl.sv
// Self-checking bench for li_rmw_ctrl: op-level scoreboard predicts per-cycle
// strobes, addresses, data and counter from accepted ops and their timing rules.
module tb_li_rmw_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        busy, done;
    logic [15:0] li_count;
    logic        load;
    logic        chk_en = 1'b0;

    li_rmw_ctrl_if bus();

    li_rmw_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .li_count (li_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_val(input int i);
        if (i == 0) return 16'h0000;
        if (i == 3) return 16'h1234;
        return (16'h0111 * i[15:0]) ^ 16'h5A00;
    endfunction

    function automatic logic [15:0] model_merge(input logic llb, input logic [15:0] b,
                                                input logic [7:0] imm);
        if (llb) return (b & 16'hFF00) | {8'h00, imm};
        return ({8'h00, imm} << 8) | (b & 16'h00FF);
    endfunction

    // Register file: synchronous read, data valid the cycle after rf_rd_en
    logic [15:0] mem [16];
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            bus.rf_rd_data <= 16'h0000;
        end else begin
            if (bus.rf_wr_en) mem[bus.rf_wr_addr] <= bus.rf_wr_data;
            if (bus.rf_rd_en) bus.rf_rd_data <= mem[bus.rf_rd_addr];
        end
    end

    typedef struct {
        int          acc_c;
        int          done_c;
        logic [3:0]  rd;
        logic [15:0] val;
        bit          fwd;
    } op_t;

    op_t         pend[$];
    logic [15:0] spec_reg [16];
    logic [15:0] commit_reg [16];
    logic [15:0] mcount;
    int          cyc = 0;
    bit          last_acc = 1'b0;
    int          rd_count = 0, wr_count = 0, last_lat = 0;
    logic [15:0] last_wr_data;
    logic [3:0]  last_wr_addr;

    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_rd_en, e_done, e_wr_en, acc, fwd;
            logic [3:0]  e_rd_addr, e_wr_addr, done_rd;
            logic [15:0] e_wr_data;
            op_t         op;
            e_rd_en = 0; e_rd_addr = 0; e_done = 0; e_wr_en = 0;
            e_wr_addr = 0; e_wr_data = 0; done_rd = 0;
            foreach (pend[i]) begin
                if (!pend[i].fwd && pend[i].done_c == cyc + 1) begin
                    e_rd_en = 1; e_rd_addr = pend[i].rd;
                end
                if (pend[i].done_c == cyc) begin
                    e_done = 1; done_rd = pend[i].rd;
                    if (pend[i].rd != 0) begin
                        e_wr_en = 1; e_wr_addr = pend[i].rd; e_wr_data = pend[i].val;
                    end
                end
            end
            chk("req_ready", bus.req_ready, !e_rd_en);
            chk("busy", busy, e_rd_en || e_done);
            chk("done", done, e_done);
            chk("rf_rd_en", bus.rf_rd_en, e_rd_en);
            chk("rf_rd_addr", bus.rf_rd_addr, e_rd_addr);
            chk("rf_wr_en", bus.rf_wr_en, e_wr_en);
            chk("rf_wr_addr", bus.rf_wr_addr, e_wr_addr);
            chk("rf_wr_data", bus.rf_wr_data, e_wr_data);
            chk("li_count", li_count, mcount);
            if (bus.rf_rd_en) rd_count++;
            if (bus.rf_wr_en) begin
                wr_count++;
                last_wr_data = bus.rf_wr_data;
                last_wr_addr = bus.rf_wr_addr;
            end
            if (e_done) begin
                op = pend.pop_front();
                if (op.rd != 0) commit_reg[op.rd] = op.val;
                mcount   = mcount + 16'd1;
                last_lat = op.done_c - op.acc_c;
            end
            acc = bus.req_valid && !e_rd_en;
            if (acc) begin
                fwd = e_done && (done_rd == bus.req_rd) && (bus.req_rd != 0);
                op.acc_c  = cyc;
                op.done_c = fwd ? cyc + 1 : cyc + 2;
                op.rd     = bus.req_rd;
                op.fwd    = fwd;
                op.val    = (bus.req_rd == 0) ? 16'h0000
                          : model_merge(bus.req_opcode[0], spec_reg[bus.req_rd], bus.req_imm);
                if (bus.req_rd != 0) spec_reg[bus.req_rd] = op.val;
                pend.push_back(op);
            end
            last_acc = acc;
            cyc++;
        end
    end

    task automatic send(input logic [3:0] opc, input logic [3:0] rd, input logic [7:0] imm);
        bit ok = 0;
        bus.req_valid = 1'b1; bus.req_opcode = opc; bus.req_rd = rd; bus.req_imm = imm;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (last_acc) begin ok = 1; break; end
        end
        chk("accept_timeout", ok, 1);
    endtask

    task automatic drain();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (pend.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_timeout", pend.size(), 0);
    endtask

    task automatic resync();
        pend.delete();
        for (int i = 0; i < 16; i++) spec_reg[i] = commit_reg[i];
        mcount   = 16'h0000;
        last_acc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdc0, wrc0;
        logic [15:0] cnt0;
        logic [3:0]  prev_rd;
        bus.req_valid = 0; bus.req_opcode = 0; bus.req_rd = 0; bus.req_imm = 0;
        load = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", bus.rf_rd_en, 0);
        chk("rst_wr_en", bus.rf_wr_en, 0);
        chk("rst_li_count", li_count, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_data", bus.rf_wr_data, 0);
        chk("rst_addrs", {bus.rf_rd_addr, bus.rf_wr_addr}, 0);
        for (int i = 0; i < 16; i++) commit_reg[i] = init_val(i);
        resync();
        rst_n = 1'b1; load = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_release", bus.req_ready, 1);
        chk_en = 1'b1;

        // LHB R3,AB on 1234
        send(4'h0, 4'd3, 8'hAB); drain();
        chk("t1_data", last_wr_data, 16'hAB34);
        chk("t1_addr", last_wr_addr, 4'd3);
        chk("t1_lat", last_lat, 2);
        chk("t1_count", li_count, 16'd1);
        chk("t1_mem", mem[3], 16'hAB34);

        // LHB R5 then LLB R5 forwarded
        rdc0 = rd_count;
        send(4'h0, 4'd5, 8'hDE); send(4'h1, 4'd5, 8'hAD); drain();
        chk("t2_reads", rd_count - rdc0, 1);
        chk("t2_data", last_wr_data, 16'hDEAD);
        chk("t2_lat", last_lat, 1);
        chk("t2_mem", mem[5], 16'hDEAD);

        // LLB R4 then LLB R2: no forwarding
        rdc0 = rd_count;
        send(4'h1, 4'd4, 8'h11); send(4'h1, 4'd2, 8'h22); drain();
        chk("t3_reads", rd_count - rdc0, 2);
        chk("t3_lat", last_lat, 2);
        chk("t3_mem", mem[2], (init_val(2) & 16'hFF00) | 16'h0022);

        // LLB R0,FF: read, no write, still counted
        rdc0 = rd_count; wrc0 = wr_count; cnt0 = li_count;
        send(4'h1, 4'd0, 8'hFF); drain();
        chk("t4_reads", rd_count - rdc0, 1);
        chk("t4_writes", wr_count - wrc0, 0);
        chk("t4_count", li_count, cnt0 + 16'd1);
        chk("t4_r0", mem[0], 16'h0000);

        // reset during READ
        chk_en = 1'b0; last_acc = 1'b0;
        bus.req_valid = 1; bus.req_opcode = 4'h1; bus.req_rd = 4'd6; bus.req_imm = 8'h77;
        @(posedge clk); #1;
        chk("t5_in_read", {busy, bus.rf_rd_en, bus.rf_rd_addr}, {1'b1, 1'b1, 4'd6});
        bus.req_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", {busy, done, bus.rf_rd_en, bus.rf_wr_en, bus.rf_rd_addr,
                            bus.rf_wr_addr}, 0);
        chk("t5_rst_data", bus.rf_wr_data, 0);
        chk("t5_rst_count", li_count, 0);
        chk("t5_rst_ready", bus.req_ready, 0);
        repeat (2) begin
            @(negedge clk);
            chk("t5_no_write", bus.rf_wr_en, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready_pre_edge", bus.req_ready, 0);
        @(posedge clk); #1;
        chk("t5_ready_post_edge", bus.req_ready, 1);
        chk("t5_mem6", mem[6], init_val(6));
        resync();
        chk_en = 1'b1;
        send(4'h1, 4'd6, 8'h77); drain();
        chk("t5_data", last_wr_data, (init_val(6) & 16'hFF00) | 16'h0077);
        chk("t5_count", li_count, 16'd1);

        // counter wrap
        force dut.count_q = 16'hFFFF;
        mcount = 16'hFFFF;
        @(posedge clk); #1;
        release dut.count_q;
        send(4'h0, 4'd7, 8'h42); drain();
        chk("t6_wrap", li_count, 16'h0000);

        // randomized traffic
        prev_rd = 4'd1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                logic [3:0] rd;
                rd = ($urandom_range(0, 1) == 1) ? prev_rd : 4'($urandom_range(0, 15));
                send(4'($urandom_range(0, 15)), rd, 8'($urandom_range(0, 255)));
                prev_rd = rd;
            end else begin
                bus.req_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        drain();
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], commit_reg[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
